// File: rtl/lpc_frame_scheduler.sv
// Ping-pong frame scheduler: fills two sample banks, starts the LPC encoder on each
// full bank in fill order, drains that bank's residual and releases the encoder.
module lpc_frame_scheduler #(
   parameter int FRAME_LEN = 256,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic              wr_bank,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              enc_start,
   output logic              enc_bank,
   input  logic              enc_rready,
   output logic              enc_rfin,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [15:0]       frame_cnt
);

   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FRAME_LEN - 1);
   localparam logic [ADDR_W-1:0] ONE_A       = ADDR_W'(1);
   localparam logic [ADDR_W:0]   FRAME_WORDS = (ADDR_W + 1)'(FRAME_LEN);
   localparam logic [ADDR_W:0]   ONE_R       = (ADDR_W + 1)'(1);

   typedef enum logic [2:0] {
      E_IDLE,
      E_START,
      E_RUN,
      E_DRAIN,
      E_FIN
   } enc_state_t;

   enc_state_t        state;
   enc_state_t        state_next;
   logic [1:0]        full;
   logic [ADDR_W-1:0] wr_cnt;
   logic [ADDR_W:0]   rd_cnt;
   logic              wr_last;
   logic              drain_begin;
   logic [1:0]        set_mask;
   logic [1:0]        clr_mask;

   // Pulse outputs are forced low while reset is asserted, whatever the old state.
   assign in_ready = !full[wr_bank];
   assign wr_en    = in_valid && in_ready && !reset;
   assign wr_addr  = wr_cnt;
   assign wr_data  = in_data;
   assign wr_last  = wr_en && (wr_cnt == LAST_ADDR);
   assign rd_addr  = rd_cnt[ADDR_W-1:0];
   assign out_data = rd_data;

   // Set and clear can hit in the same cycle; they always target different banks.
   assign set_mask = wr_last  ? (wr_bank  ? 2'b10 : 2'b01) : 2'b00;
   assign clr_mask = enc_rfin ? (enc_bank ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge clk) begin
      if (reset) begin
         full    <= 2'b00;
         wr_bank <= 1'b0;
         wr_cnt  <= '0;
      end else begin
         full <= (full & ~clr_mask) | set_mask;
         if (wr_en) begin
            if (wr_last) begin
               wr_cnt  <= '0;
               wr_bank <= ~wr_bank;
            end else begin
               wr_cnt <= wr_cnt + ONE_A;
            end
         end
      end
   end

   always_comb begin
      state_next  = state;
      enc_start   = 1'b0;
      enc_rfin    = 1'b0;
      rd_en       = 1'b0;
      drain_begin = 1'b0;
      case (state)
         E_IDLE: begin
            if (full[enc_bank]) state_next = E_START;
         end
         E_START: begin
            enc_start  = !reset;
            state_next = E_RUN;
         end
         E_RUN: begin
            if (enc_rready) begin
               drain_begin = 1'b1;
               state_next  = E_DRAIN;
            end
         end
         E_DRAIN: begin
            // At most one word in flight: a read only issues when the output slot frees up.
            rd_en = !reset && (rd_cnt < FRAME_WORDS) && (!out_valid || out_ready);
            if ((rd_cnt == FRAME_WORDS) && out_valid && out_ready) state_next = E_FIN;
         end
         E_FIN: begin
            enc_rfin   = !reset;
            state_next = E_IDLE;
         end
         default: state_next = E_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= E_IDLE;
         rd_cnt    <= '0;
         out_valid <= 1'b0;
         enc_bank  <= 1'b0;
         frame_cnt <= 16'd0;
      end else begin
         state <= state_next;
         if (drain_begin) begin
            rd_cnt <= '0;
         end else if (rd_en) begin
            rd_cnt <= rd_cnt + ONE_R;
         end
         if (rd_en) begin
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (enc_rfin) begin
            enc_bank  <= ~enc_bank;
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

endmodule
